// File: rtl/multicycle_rv32_core.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB state machine over a
// combinational instruction ROM and an internal data RAM, halting on ECALL/illegal/misaligned.
module multicycle_rv32_core #(
  parameter int          IMEM_WORDS = 32,
  parameter int          DMEM_WORDS = 32,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [IMEM_WORDS-1:0][31:0]  imem_init,
  output logic [31:0]                  pc_out,
  output logic [2:0]                   state_out,
  output logic                         retire,
  output logic                         halted,
  output logic [31:0][31:0]            reg_check,
  output logic [DMEM_WORDS-1:0][31:0]  dmem_check
);

  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t                        state_q;
  logic [31:0]                   pc_q;
  logic [31:0]                   ir_q;
  logic [31:0]                   rs1v_q;
  logic [31:0]                   rs2v_q;
  logic [31:0]                   imm_q;
  logic [31:0]                   alu_q;
  logic [31:0]                   mdr_q;
  logic                          take_q;
  logic                          retire_q;
  logic                          halted_q;
  logic [31:0][31:0]             rf_q;
  logic [DMEM_WORDS-1:0][31:0]   dmem_q;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_d;
  logic        legal_d;
  logic        alt_d;
  logic [31:0] opb_d;
  logic [31:0] exec_d;
  logic        take_d;
  logic        is_mem;
  logic        misaligned;
  logic [DA-1:0] didx;
  logic        writes_rd;
  logic [31:0] wdata;

  function automatic logic [31:0] alu_op(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    case (f3)
      3'b000:  alu_op = alt ? (a - b) : (a + b);
      3'b001:  alu_op = a << b[4:0];
      3'b010:  alu_op = {31'b0, (sa < sb)};
      3'b011:  alu_op = {31'b0, (a < b)};
      3'b100:  alu_op = a ^ b;
      3'b101:  alu_op = alt ? 32'(sa >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  alu_op = a | b;
      default: alu_op = a & b;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    case (f3)
      3'b000:  br_taken = (a == b);
      3'b001:  br_taken = (a != b);
      3'b100:  br_taken = (sa < sb);
      3'b101:  br_taken = (sa >= sb);
      3'b110:  br_taken = (a < b);
      3'b111:  br_taken = (a >= b);
      default: br_taken = 1'b0;
    endcase
  endfunction

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  always_comb begin
    imm_d   = 32'h0;
    legal_d = 1'b0;
    case (opcode)
      OP_R: begin
        legal_d = (funct7 == 7'h00) ||
                  (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OP_IMM: begin
        imm_d = {{20{ir_q[31]}}, ir_q[31:20]};
        if (funct3 == 3'b001)      legal_d = (funct7 == 7'h00);
        else if (funct3 == 3'b101) legal_d = (funct7 == 7'h00) || (funct7 == 7'h20);
        else                       legal_d = 1'b1;
      end
      OP_LOAD: begin
        imm_d   = {{20{ir_q[31]}}, ir_q[31:20]};
        legal_d = (funct3 == 3'b010);
      end
      OP_STORE: begin
        imm_d   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
        legal_d = (funct3 == 3'b010);
      end
      OP_BRANCH: begin
        imm_d   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
        legal_d = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OP_JAL: begin
        imm_d   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
        legal_d = 1'b1;
      end
      OP_LUI: begin
        imm_d   = {ir_q[31:12], 12'h0};
        legal_d = 1'b1;
      end
      default: legal_d = 1'b0;
    endcase
  end

  // ir[30] selects SUB/SRA only where it is a funct7 bit, never an ADDI immediate bit
  assign alt_d = ir_q[30] && ((opcode == OP_R) || (funct3 == 3'b101));
  assign opb_d = (opcode == OP_R) ? rs2v_q : imm_q;

  always_comb begin
    exec_d = 32'h0;
    case (opcode)
      OP_R, OP_IMM:      exec_d = alu_op(funct3, alt_d, rs1v_q, opb_d);
      OP_LOAD, OP_STORE: exec_d = rs1v_q + imm_q;
      OP_LUI:            exec_d = imm_q;
      OP_JAL:            exec_d = pc_q + 32'd4;
      default:           exec_d = 32'h0;
    endcase
  end

  assign take_d     = (opcode == OP_BRANCH) ? br_taken(funct3, rs1v_q, rs2v_q)
                                            : (opcode == OP_JAL);
  assign is_mem     = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign misaligned = |alu_q[1:0];
  assign didx       = alu_q[DA+1:2];
  assign writes_rd  = (opcode == OP_R) || (opcode == OP_IMM) || (opcode == OP_LOAD) ||
                      (opcode == OP_LUI) || (opcode == OP_JAL);
  assign wdata      = (opcode == OP_LOAD) ? mdr_q : alu_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 32'h0;
      rf_q     <= '0;
      dmem_q   <= '0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          ir_q    <= imem_init[pc_q[IA+1:2]];
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (!legal_d) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            rs1v_q  <= rf_q[rs1];
            rs2v_q  <= rf_q[rs2];
            imm_q   <= imm_d;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_q  <= exec_d;
          take_q <= take_d;
          if (is_mem) begin
            state_q <= S_MEM;
          end else begin
            state_q  <= S_WB;
            retire_q <= 1'b1;
          end
        end
        S_MEM: begin
          if (misaligned) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            if (opcode == OP_STORE) dmem_q[didx] <= rs2v_q;
            else                    mdr_q        <= dmem_q[didx];
            state_q  <= S_WB;
            retire_q <= 1'b1;
          end
        end
        S_WB: begin
          if (writes_rd && rd != 5'd0) rf_q[rd] <= wdata;
          pc_q    <= take_q ? (pc_q + imm_q) : (pc_q + 32'd4);
          state_q <= S_FETCH;
        end
        S_HALT: state_q <= S_HALT;
        default: begin
          state_q  <= S_HALT;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign pc_out     = pc_q;
  assign state_out  = state_q;
  assign retire     = retire_q;
  assign halted     = halted_q;
  assign reg_check  = rf_q;
  assign dmem_check = dmem_q;

endmodule

// File: tb/tb_multicycle_rv32_core.sv
// Bench for multicycle_rv32_core: table of small programs with hand-derived results,
// retire-PC scoreboard, plus halt / ECALL / illegal / reset-mid-store sequences.
module tb_multicycle_rv32_core;
  localparam int IW = 32;
  localparam int DW = 32;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [IW-1:0][31:0]   imem = '0;
  logic [31:0]           pc_out;
  logic [2:0]            state_out;
  logic                  retire;
  logic                  halted;
  logic [31:0][31:0]     reg_check;
  logic [DW-1:0][31:0]   dmem_check;

  multicycle_rv32_core #(.IMEM_WORDS(IW), .DMEM_WORDS(DW), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_init  (imem),
    .pc_out     (pc_out),
    .state_out  (state_out),
    .retire     (retire),
    .halted     (halted),
    .reg_check  (reg_check),
    .dmem_check (dmem_check)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][31:0] prog;
    logic [3:0][31:0] pcs;
    int               n;
    int               cyc;
    logic [31:0]      pc_exp;
    int               ra;
    logic [31:0]      va;
    int               rb;
    logic [31:0]      vb;
    int               dix;
    logic [31:0]      dv;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_and_reset(input logic [31:0] p0, input logic [31:0] p1,
                                input logic [31:0] p2, input logic [31:0] p3);
    imem    = '0;
    imem[0] = p0;
    imem[1] = p1;
    imem[2] = p2;
    imem[3] = p3;
    reset   = 1'b1;
    step();
    step();
    reset   = 1'b0;
    exp_q.delete();
  endtask

  task automatic addv(input logic [31:0] p0, p1, p2, p3,
                      input logic [31:0] c0, c1, c2, c3,
                      input int n, input int cyc, input logic [31:0] pcx,
                      input int ra, input logic [31:0] va,
                      input int rb, input logic [31:0] vb,
                      input int dix, input logic [31:0] dv);
    vec_t t;
    t.prog[0] = p0; t.prog[1] = p1; t.prog[2] = p2; t.prog[3] = p3;
    t.pcs[0]  = c0; t.pcs[1]  = c1; t.pcs[2]  = c2; t.pcs[3]  = c3;
    t.n = n; t.cyc = cyc; t.pc_exp = pcx;
    t.ra = ra; t.va = va; t.rb = rb; t.vb = vb; t.dix = dix; t.dv = dv;
    vecs.push_back(t);
  endtask

  // Runs until n retires (bounded), popping expected PCs; then one more cycle to commit WB.
  task automatic run(input int n, input int budget, output int last_cyc);
    int   seen;
    logic prev;
    seen = 0;
    prev = 1'b0;
    last_cyc = 0;
    for (int k = 1; k <= budget && seen < n; k++) begin
      step();
      if (retire) begin
        seen++;
        check("retire_gap", 32'(prev), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL retire_unexpected: pc %h with empty scoreboard", pc_out);
        end else begin
          check("retire_pc", pc_out, exp_q.pop_front());
        end
        last_cyc = k + 1;
      end
      prev = retire;
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: retired %0d required %0d", seen, n);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lc;
    bit saw;

    addv(32'h00500093, 0, 0, 0,                               0, 0, 0, 0, 1, 4, 32'd4,  1, 32'd5, 2, 32'd0, -1, 0);
    addv(32'h00500093, 32'hFFF00113, 32'h401151B3, 0,         0, 4, 8, 0, 3, 12, 32'd12, 2, 32'hFFFFFFFF, 3, 32'hFFFFFFFF, -1, 0);
    addv(32'h00500093, 32'hFFF00113, 32'h001151B3, 0,         0, 4, 8, 0, 3, 12, 32'd12, 1, 32'd5, 3, 32'h07FFFFFF, -1, 0);
    addv(32'h00500093, 32'h00102223, 32'h00402203, 0,         0, 4, 8, 0, 3, 14, 32'd12, 4, 32'd5, 1, 32'd5, 1, 32'd5);
    addv(32'h00000463, 32'h00100093, 32'h00200113, 0,         0, 8, 0, 0, 2, 8, 32'd12,  1, 32'd0, 2, 32'd2, -1, 0);
    addv(32'h123450B7, 0, 0, 0,                               0, 0, 0, 0, 1, 4, 32'd4,  1, 32'h12345000, 2, 32'd0, -1, 0);
    addv(32'hFFF00093, 32'h0000A133, 32'h0000B1B3, 0,         0, 4, 8, 0, 3, 12, 32'd12, 2, 32'd1, 3, 32'd0, -1, 0);
    addv(32'h008000EF, 32'h00100193, 32'h00200113, 0,         0, 8, 0, 0, 2, 8, 32'd12,  1, 32'd4, 2, 32'd2, -1, 0);
    addv(32'h00500093, 32'h00109463, 32'h00200113, 0,         0, 4, 8, 0, 3, 12, 32'd12, 1, 32'd5, 2, 32'd2, -1, 0);
    addv(32'h00500013, 32'h00100093, 0, 0,                    0, 4, 0, 0, 2, 8, 32'd8,   0, 32'd0, 1, 32'd1, -1, 0);
    addv(32'h00500093, 32'h001080B3, 0, 0,                    0, 4, 0, 0, 2, 8, 32'd8,   1, 32'd10, 2, 32'd0, -1, 0);
    addv(32'h00500093, 32'h40100133, 0, 0,                    0, 4, 0, 0, 2, 8, 32'd8,   1, 32'd5, 2, 32'hFFFFFFFB, -1, 0);
    addv(32'hFFF00093, 32'h0000C463, 32'h00200113, 32'h00300193, 0, 4, 12, 0, 3, 12, 32'd16, 2, 32'd0, 3, 32'd3, -1, 0);
    addv(32'hFFF00093, 32'h0000E463, 32'h00200113, 32'h00300193, 0, 4, 8, 0, 3, 12, 32'd12, 2, 32'd2, 3, 32'd0, -1, 0);

    // State sequence and reset values for a single ADDI
    load_and_reset(32'h00500093, 0, 0, 0);
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    step(); check("seq_decode", 32'(state_out), 32'd1);
    step(); check("seq_exec", 32'(state_out), 32'd2);
    step(); check("seq_wb", 32'(state_out), 32'd4);
    check("seq_retire", 32'(retire), 32'd1);
    step(); check("seq_fetch", 32'(state_out), 32'd0);
    check("seq_retire_low", 32'(retire), 32'd0);
    check("seq_x1", reg_check[1], 32'd5);
    check("seq_pc", pc_out, 32'd4);

    for (int v = 0; v < vecs.size(); v++) begin
      load_and_reset(vecs[v].prog[0], vecs[v].prog[1], vecs[v].prog[2], vecs[v].prog[3]);
      check($sformatf("v%0d_rst_pc", v), pc_out, 32'h0);
      check($sformatf("v%0d_rst_reg", v), reg_check[vecs[v].ra], 32'd0);
      for (int i = 0; i < vecs[v].n; i++) exp_q.push_back(vecs[v].pcs[i]);
      run(vecs[v].n, 60, lc);
      check($sformatf("v%0d_cycles", v), 32'(lc), 32'(vecs[v].cyc));
      check($sformatf("v%0d_pc", v), pc_out, vecs[v].pc_exp);
      check($sformatf("v%0d_x%0d", v, vecs[v].ra), reg_check[vecs[v].ra], vecs[v].va);
      check($sformatf("v%0d_x%0d", v, vecs[v].rb), reg_check[vecs[v].rb], vecs[v].vb);
      check($sformatf("v%0d_x0", v), reg_check[0], 32'd0);
      if (vecs[v].dix >= 0)
        check($sformatf("v%0d_dmem%0d", v, vecs[v].dix), dmem_check[vecs[v].dix], vecs[v].dv);
    end

    // Misaligned LW halts in MEM with no writeback
    load_and_reset(32'h00700293, 32'h00102283, 0, 0);
    exp_q.push_back(32'h0);
    run(1, 20, lc);
    saw = 1'b0;
    for (int k = 0; k < 10 && !halted; k++) begin
      step();
      if (retire) saw = 1'b1;
    end
    check("mis_no_retire", 32'(saw), 32'd0);
    check("mis_halted", 32'(halted), 32'd1);
    check("mis_state", 32'(state_out), 32'd5);
    check("mis_x5", reg_check[5], 32'd7);
    check("mis_pc", pc_out, 32'd4);
    step(); step(); step();
    check("mis_pc_frozen", pc_out, 32'd4);
    check("mis_state_frozen", 32'(state_out), 32'd5);
    check("mis_retire_low", 32'(retire), 32'd0);

    // ECALL halts straight out of DECODE
    load_and_reset(32'h00000073, 0, 0, 0);
    step(); check("ecall_decode", 32'(state_out), 32'd1);
    step(); check("ecall_state", 32'(state_out), 32'd5);
    check("ecall_halted", 32'(halted), 32'd1);
    check("ecall_pc", pc_out, 32'd0);

    // SLLI with funct7=0x20 is illegal
    load_and_reset(32'h40109093, 0, 0, 0);
    step(); step();
    check("illegal_slli_state", 32'(state_out), 32'd5);
    check("illegal_slli_x1", reg_check[1], 32'd0);

    // Reset while SW sits in MEM: no store, clean restart
    load_and_reset(32'h00500093, 32'h00102223, 0, 0);
    exp_q.push_back(32'h0);
    run(1, 20, lc);
    step(); step(); step();
    check("rmem_state", 32'(state_out), 32'd3);
    reset = 1'b1;
    step();
    check("rmem_dmem", dmem_check[1], 32'd0);
    check("rmem_pc", pc_out, 32'd0);
    check("rmem_x1", reg_check[1], 32'd0);
    check("rmem_state_rst", 32'(state_out), 32'd0);
    check("rmem_retire", 32'(retire), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    run(2, 30, lc);
    check("rmem_restart_cycles", 32'(lc), 32'd9);
    check("rmem_restart_dmem", dmem_check[1], 32'd5);
    check("rmem_restart_pc", pc_out, 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
